// File: rtl/booth_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential radix-2 Booth multiplier:
//   - state_t / IDLE / RUN     : two-state controller encoding
//   - booth_op_t / BOOTH_*     : action selected by a Booth bit pair
//   - count_width()            : width of the step counter for a given WIDTH
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    typedef logic [1:0] booth_op_t;

    localparam booth_op_t BOOTH_NOP = 2'd0;
    localparam booth_op_t BOOTH_ADD = 2'd1;
    localparam booth_op_t BOOTH_SUB = 2'd2;

    // The counter is loaded with WIDTH+1, so it must hold values up to WIDTH+1.
    function automatic int count_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_if
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
//   start     : request a multiply (master -> slave)
//   is_signed : 1 = two's-complement operands, 0 = unsigned
//   a, b      : multiplicand / multiplier, WIDTH bits
//   busy      : operation in flight (slave -> master)
//   done      : one-cycle pulse when hi/lo are updated
//   hi, lo    : upper / lower half of the 2*WIDTH product
// Modports: master = control unit side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/booth_mult_seq_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration on (WIDTH+1)-bit registers.
//   acc_in, q_in, q1_in : current {A, Q, q_1}
//   m                   : extended multiplicand M
//   acc_out, q_out, q1_out : {A, Q, q_1} after add/sub and arithmetic shift
// -----------------------------------------------------------------------------
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] acc_in,
    input  logic [WIDTH:0] q_in,
    input  logic           q1_in,
    input  logic [WIDTH:0] m,
    output logic [WIDTH:0] acc_out,
    output logic [WIDTH:0] q_out,
    output logic           q1_out
);

    booth_op_t      op;
    logic [WIDTH:0] sum;

    // Bit pair 01 ends a run of ones (add M), 10 starts one (subtract M).
    always_comb begin
        op = BOOTH_NOP;
        if ({q_in[0], q1_in} == 2'b01) begin
            op = BOOTH_ADD;
        end else if ({q_in[0], q1_in} == 2'b10) begin
            op = BOOTH_SUB;
        end
    end

    // A and M carry one guard bit, so these wrap-around results never overflow.
    always_comb begin
        sum = acc_in;
        if (op == BOOTH_ADD) begin
            sum = acc_in + m;
        end else if (op == BOOTH_SUB) begin
            sum = acc_in - m;
        end
    end

    // Arithmetic right shift of {A, Q, q_1}, replicating A's sign bit.
    always_comb begin
        acc_out = {sum[WIDTH], sum[WIDTH:1]};
        q_out   = {sum[0], q_in[WIDTH:1]};
        q1_out  = q_in[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Latency is WIDTH+1 cycles from the accepting edge; a start in the done
// cycle is accepted, giving back-to-back issue every WIDTH+2 cycles.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears all state and outputs
//   bus   : booth_mult_seq_if slave (start, is_signed, a, b, busy, done, hi, lo)
// -----------------------------------------------------------------------------
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    booth_mult_seq_if.slave      bus
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH:0]   q_reg;
    logic             q1_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH:0]   q_next;
    logic             q1_next;

    // One extra bit lets unsigned all-ones and signed most-negative share one datapath.
    assign a_ext = {bus.is_signed & bus.a[WIDTH-1], bus.a};
    assign b_ext = {bus.is_signed & bus.b[WIDTH-1], bus.b};

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_in  (acc_reg),
        .q_in    (q_reg),
        .q1_in   (q1_reg),
        .m       (m_reg),
        .acc_out (acc_next),
        .q_out   (q_next),
        .q1_out  (q1_next)
    );

    // Controller: latch operands on an accepted start, then run WIDTH+1 steps.
    // On the last step the shifted {A, Q} is the product; its top two bits are
    // redundant extension bits and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            m_reg    <= '0;
            acc_reg  <= '0;
            q_reg    <= '0;
            q1_reg   <= 1'b0;
            done_reg <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    m_reg   <= a_ext;
                    acc_reg <= '0;
                    q_reg   <= b_ext;
                    q1_reg  <= 1'b0;
                    count   <= CW'(WIDTH + 1);
                    state   <= RUN;
                end
            end else begin
                acc_reg <= acc_next;
                q_reg   <= q_next;
                q1_reg  <= q1_next;
                count   <= count - CW'(1);
                if (count == CW'(1)) begin
                    hi_reg   <= {acc_next[WIDTH-2:0], q_next[WIDTH]};
                    lo_reg   <= q_next[WIDTH-1:0];
                    done_reg <= 1'b1;
                    state    <= IDLE;
                end
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule
